// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate controller that feeds the ALU's
// single-step shifter. It captures one operand, a mode and an amount, then
// applies the same 1-bit step once per clock until the amount runs out. The
// final word is presented with a one-cycle done pulse.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       request pulse, only sampled in IDLE
//   A           operand, captured on the accepted start
//   amt         shift count, captured on the accepted start (saturates at WIDTH)
//   S2, S3      mode bits {S2,S3}: 00 ror, 01 rol, 10 lsr, 11 lsl
//   busy        high while shifting
//   done        one-cycle pulse, result valid
//   result      shifted word, held from done until the next accepted start
//   steps_left  remaining step count (debug), 0 in IDLE and DONE
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AMT_W-1:0] amt,
    input  logic             S2,
    input  logic             S3,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [AMT_W-1:0] steps_left
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       mode_q, mode_d;
    logic [AMT_W-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [AMT_W-1:0] amt_eff;
    logic [WIDTH-1:0] work_step;

    // One 1-bit step of the selected operation.
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                               input logic [1:0] m);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = {v[0], v[WIDTH-1:1]};
            2'b01:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            2'b10:   r = {1'b0, v[WIDTH-1:1]};
            default: r = {v[WIDTH-2:0], 1'b0};
        endcase
        return r;
    endfunction

    // Amounts beyond WIDTH behave exactly like WIDTH.
    assign amt_eff   = (amt > AMT_MAX) ? AMT_MAX : amt;
    assign work_step = step1(work_q, mode_q);

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        mode_d   = mode_q;
        steps_d  = steps_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = A;
                    mode_d = {S2, S3};
                    if (amt_eff == '0) begin
                        // Nothing to shift: report the operand straight away.
                        steps_d  = '0;
                        result_d = A;
                        state_d  = ST_DONE;
                    end else begin
                        steps_d = amt_eff;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = work_step;
                steps_d = steps_q - 1'b1;
                if (steps_q == AMT_W'(1)) begin
                    result_d = work_step;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                steps_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            mode_q   <= 2'b00;
            steps_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            steps_q  <= steps_d;
            result_q <= result_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign result     = result_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [3:0] amt;
    logic       S2, S3;
    logic       busy, done;
    logic [7:0] result;
    logic [3:0] steps_left;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .amt(amt),
        .S2(S2), .S3(S3), .busy(busy), .done(done), .result(result),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 result=%0h expected no done", result);
            end else begin
                chk("sb_result", {24'h0, result}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [1:0] mode;
        logic [3:0] amt;
        logic [7:0] res;
        int         n;
    } vec_t;

    vec_t vecs[$];

    // Issue one request and check latency, busy length and hold behaviour.
    // noise=1 pulses start with A=FF during the shift; it must be ignored.
    task automatic run_op(input logic [7:0] ta, input logic [1:0] tm, input logic [3:0] tn,
                          input logic [7:0] tres, input int n, input bit noise);
        int idx;
        int bcnt;
        bit seen;
        @(negedge clk);
        A = ta; {S2, S3} = tm; amt = tn; start = 1'b1;
        exp_q.push_back(tres);
        @(negedge clk);
        start = 1'b0;
        A = ~ta; amt = 4'd1; {S2, S3} = ~tm;  // inputs after accept must not matter
        bcnt = 0; seen = 1'b0; idx = 1;
        while (idx <= 20) begin
            if (idx == 1 && n > 0) chk("steps_first", {28'h0, steps_left}, n);
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (noise && idx == 2) begin start = 1'b1; A = 8'hFF; end
            if (noise && idx == 4) start = 1'b0;
            @(negedge clk);
            idx++;
        end
        chk("done_seen", {31'h0, seen}, 1);
        if (seen) chk("done_latency", idx, n + 1);
        chk("busy_cycles", bcnt, n);
        chk("steps_at_done", {28'h0, steps_left}, 0);
        @(negedge clk);
        chk("hold_done_low", {31'h0, done}, 0);
        chk("hold_result", {24'h0, result}, {24'h0, tres});
    endtask

    initial begin
        vecs.push_back('{8'hB4, 2'b00, 4'd3,  8'h96, 3});
        vecs.push_back('{8'hB4, 2'b01, 4'd1,  8'h69, 1});
        vecs.push_back('{8'hB4, 2'b11, 4'd2,  8'hD0, 2});
        vecs.push_back('{8'hB4, 2'b10, 4'd0,  8'hB4, 0});
        vecs.push_back('{8'hB4, 2'b01, 4'd12, 8'hB4, 8});
        vecs.push_back('{8'hB4, 2'b10, 4'd9,  8'h00, 8});
        vecs.push_back('{8'h81, 2'b00, 4'd1,  8'hC0, 1});
        vecs.push_back('{8'h81, 2'b10, 4'd1,  8'h40, 1});
        vecs.push_back('{8'h81, 2'b11, 4'd1,  8'h02, 1});
        vecs.push_back('{8'h0F, 2'b11, 4'd4,  8'hF0, 4});
        vecs.push_back('{8'hF0, 2'b00, 4'd4,  8'h0F, 4});
        vecs.push_back('{8'h0F, 2'b10, 4'd4,  8'h00, 4});
        vecs.push_back('{8'hA5, 2'b10, 4'd8,  8'h00, 8});
        vecs.push_back('{8'h3C, 2'b00, 4'd15, 8'h3C, 8});

        // Reset with start held high: nothing may be accepted.
        rst_n = 1'b0; start = 1'b1; A = 8'h5A; amt = 4'd3; S2 = 1'b0; S3 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", {31'h0, busy}, 0);
            chk("rst_done", {31'h0, done}, 0);
            chk("rst_result", {24'h0, result}, 0);
            chk("rst_steps", {28'h0, steps_left}, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 0);
        chk("idle_done", {31'h0, done}, 0);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].mode, vecs[i].amt, vecs[i].res, vecs[i].n, 1'b0);

        // Start during SHIFT is ignored: B4 ror 5 = A5.
        run_op(8'hB4, 2'b00, 4'd5, 8'hA5, 5, 1'b1);

        // Reset mid-operation: discarded, no done pulse.
        @(negedge clk);
        A = 8'hB4; {S2, S3} = 2'b11; amt = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_before_rst", {31'h0, busy}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'h0, busy}, 0);
        chk("midrst_done", {31'h0, done}, 0);
        chk("midrst_result", {24'h0, result}, 0);
        chk("midrst_steps", {28'h0, steps_left}, 0);
        repeat (8) @(negedge clk);  // scoreboard flags any stray done
        run_op(8'hB4, 2'b00, 4'd3, 8'h96, 3, 1'b0);

        // Back-to-back with start held: accepts every 4 cycles, dones at 3, 7, 11.
        begin
            int dcnt;
            int didx[3];
            dcnt = 0;
            @(negedge clk);
            A = 8'hB4; {S2, S3} = 2'b11; amt = 4'd2; start = 1'b1;
            repeat (3) exp_q.push_back(8'hD0);
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (done) begin
                    if (dcnt < 3) didx[dcnt] = i;
                    dcnt++;
                end
                if (i == 11) start = 1'b0;
            end
            chk("b2b_count", dcnt, 3);
            if (dcnt >= 3) begin
                chk("b2b_done0", didx[0], 3);
                chk("b2b_done1", didx[1], 7);
                chk("b2b_done2", didx[2], 11);
            end
            repeat (4) @(negedge clk);
            chk("b2b_idle", {31'h0, busy}, 0);
        end

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
